csa_acc_ctrl: RTL and testbench

- Sequencing stage wrapped around the 51-bit carry-select adder.
- Accepts a valid/ready stream of operands and drives the adder with (running accumulator, incoming operand).
- Captures the adder's sum and carry-out each accepted beat.
- On the beat flagged last, presents the total, the carry count and the overflow flags downstream via valid/ready.

---
 rtl/csa_acc_pkg.sv | 14 +
 rtl/csa_acc_satcnt.sv | 28 ++
 rtl/csa_acc_ctrl.sv | 103 ++++++++++
 tb/tb_csa_acc_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and defaults for the carry-select accumulate controller.
// Holds FSM encodings and default operand / counter widths.
package csa_acc_pkg;

    localparam int WIDTH_DEF = 51;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csa_acc_satcnt.sv
// Saturating carry-out counter with synchronous clear and sticky overflow.
// Overflow latches when an increment arrives while the count is at max.
module csa_acc_satcnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    // count up to all-ones, then hold and flag any further increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/csa_acc_ctrl.sv
// Sequencer feeding an external carry-select adder with (acc, operand).
// Define CSA_ACC_SAT_EN to saturate acc at all-ones on adder carry-out.
module csa_acc_ctrl
    import csa_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic [WIDTH-1:0] o_add_term1,
    output logic [WIDTH-1:0] o_add_term2,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [CNT_W-1:0] o_carry_cnt,
    output logic             o_cnt_ovf
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             beat;
    logic             done_hs;

    assign o_ready = (state != S_DONE);
    assign o_valid = (state == S_DONE);
    assign beat    = i_valid & o_ready;
    assign done_hs = o_valid & i_ready;

    assign o_add_term1 = acc;
    assign o_add_term2 = beat ? i_data : '0;

`ifdef CSA_ACC_SAT_EN
    assign acc_next = i_cout ? '1 : i_sum;
`else
    assign acc_next = i_sum;
`endif

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state: absorb beats until last, then hold until taken
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_ACC: begin
                if (beat) begin
                    state_next = i_last ? S_DONE : S_ACC;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // running accumulator, cleared when the result is consumed
    always_ff @(posedge i_clk) begin
        if (i_rst || done_hs) begin
            acc <= '0;
        end else if (beat) begin
            acc <= acc_next;
        end
    end

    // result latched from the final beat of a group
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_result <= '0;
        end else if (beat && i_last) begin
            o_result <= acc_next;
        end
    end

    csa_acc_satcnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (i_clk),
        .rst (i_rst),
        .clr (done_hs),
        .inc (beat & i_cout),
        .cnt (o_carry_cnt),
        .ovf (o_cnt_ovf)
    );

endmodule

// File: tb/tb_csa_acc_ctrl.sv
// Randomized bench for csa_acc_ctrl, CNT_W=8 and CNT_W=2 side by side.
// Each DUT gets its own behavioural adder; the checker is an arithmetic model.
module tb_csa_acc_ctrl;

    localparam int W = 51;
    localparam logic [63:0] MAXV = 64'h0007_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAX8 = 64'd255;
    localparam logic [63:0] MAX2 = 64'd3;

    logic         clk;
    logic         rst;
    logic         vin;
    logic [W-1:0] din;
    logic         lin;
    logic         rin;

    logic         rdy0, rdy1, val0, val1, c0, c1, ovf0, ovf1;
    logic [W-1:0] t1_0, t2_0, s0, res0;
    logic [W-1:0] t1_1, t2_1, s1, res1;
    logic [7:0]   cnt0;
    logic [1:0]   cnt1;
    logic [W:0]   wide0, wide1;

    assign wide0 = {1'b0, t1_0} + {1'b0, t2_0};
    assign s0    = wide0[W-1:0];
    assign c0    = wide0[W];
    assign wide1 = {1'b0, t1_1} + {1'b0, t2_1};
    assign s1    = wide1[W-1:0];
    assign c1    = wide1[W];

    csa_acc_ctrl #(.WIDTH(W), .CNT_W(8)) u0 (
        .i_clk(clk), .i_rst(rst), .i_valid(vin), .o_ready(rdy0),
        .i_data(din), .i_last(lin), .o_add_term1(t1_0),
        .o_add_term2(t2_0), .i_sum(s0), .i_cout(c0), .o_valid(val0),
        .i_ready(rin), .o_result(res0), .o_carry_cnt(cnt0),
        .o_cnt_ovf(ovf0)
    );

    csa_acc_ctrl #(.WIDTH(W), .CNT_W(2)) u1 (
        .i_clk(clk), .i_rst(rst), .i_valid(vin), .o_ready(rdy1),
        .i_data(din), .i_last(lin), .o_add_term1(t1_1),
        .o_add_term2(t2_1), .i_sum(s1), .i_cout(c1), .o_valid(val1),
        .i_ready(rin), .o_result(res1), .o_carry_cnt(cnt1),
        .o_cnt_ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: group-level arithmetic, no notion of the RTL encoding
    logic [63:0] m_acc;
    logic [63:0] m_res;
    int          m_raw;
    bit          m_pend;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat_cnt(input int raw,
                                            input logic [63:0] mx);
        return (64'(raw) > mx) ? mx : 64'(raw);
    endfunction

    task automatic check_out();
        chk("valid8", 64'(val0), 64'(m_pend));
        chk("valid2", 64'(val1), 64'(m_pend));
        if (m_pend) begin
            chk("result8", 64'(res0), m_res);
            chk("result2", 64'(res1), m_res);
            chk("cnt8", 64'(cnt0), sat_cnt(m_raw, MAX8));
            chk("cnt2", 64'(cnt1), sat_cnt(m_raw, MAX2));
            chk("ovf8", 64'(ovf0), 64'(64'(m_raw) > MAX8));
            chk("ovf2", 64'(ovf1), 64'(64'(m_raw) > MAX2));
        end
    endtask

    // one clock: drive at negedge, check comb outputs, update model, check
    task automatic step(input logic v, input logic [W-1:0] d,
                        input logic l, input logic r);
        logic        acc_ok;
        logic [63:0] s;
        acc_ok = !m_pend;
        vin = v; din = d; lin = l; rin = r;
        #1;
        chk("ready8", 64'(rdy0), 64'(acc_ok));
        chk("ready2", 64'(rdy1), 64'(acc_ok));
        chk("term1_8", 64'(t1_0), m_acc);
        chk("term1_2", 64'(t1_1), m_acc);
        chk("term2_8", 64'(t2_0), (v && acc_ok) ? 64'(d) : 64'd0);
        chk("term2_2", 64'(t2_1), (v && acc_ok) ? 64'(d) : 64'd0);
        @(posedge clk);
        if (m_pend) begin
            if (r) begin
                m_pend = 1'b0;
                m_acc  = 64'd0;
                m_raw  = 0;
            end
        end else if (v) begin
            s = m_acc + 64'(d);
            if (s > MAXV) begin
                m_raw++;
`ifdef CSA_ACC_SAT_EN
                m_acc = MAXV;
`else
                m_acc = s & MAXV;
`endif
            end else begin
                m_acc = s;
            end
            if (l) begin
                m_pend = 1'b1;
                m_res  = m_acc;
            end
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic do_reset(input logic v);
        rst = 1'b1; vin = v; din = W'(123); lin = 1'b1; rin = 1'b0;
        @(posedge clk);
        m_acc = 64'd0; m_res = 64'd0; m_raw = 0; m_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 64'(val0 | val1), 64'd0);
        chk("rst_res8", 64'(res0), 64'd0);
        chk("rst_res2", 64'(res1), 64'd0);
        chk("rst_ready", 64'({rdy0, rdy1}), 64'd3);
        chk("rst_cnt", 64'({cnt0, cnt1}), 64'd0);
        chk("rst_ovf", 64'({ovf0, ovf1}), 64'd0);
        chk("rst_acc", 64'(t1_0 | t1_1), 64'd0);
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: return W'($urandom_range(0, 255));
            1: return W'(MAXV);
            default: return r[W-1:0];
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_acc = 0; m_res = 0; m_raw = 0; m_pend = 0;
        rst = 1'b1; vin = 0; din = '0; lin = 0; rin = 0;
        @(negedge clk);
        @(negedge clk);
        do_reset(1'b1);

        // 5 + 7 + 9 = 21
        step(1, W'(5), 0, 1);
        step(1, W'(7), 0, 1);
        step(1, W'(9), 1, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        // wrap (or saturate) on all-ones + 3
        step(1, W'(MAXV), 0, 1);
        step(1, W'(3), 1, 1);
        step(0, '0, 0, 1);

        // single beat held while downstream stalls, then fresh group
        step(1, W'(16'h1234), 1, 0);
        for (int i = 0; i < 4; i++) step(1, W'(77), 1, 0);
        step(0, '0, 0, 1);
        step(1, W'(1), 0, 1);
        step(1, W'(1), 1, 1);
        step(0, '0, 0, 1);

        // five all-ones beats: narrow counter saturates and flags
        for (int i = 0; i < 5; i++) step(1, W'(MAXV), (i == 4), 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);

        // gaps, stray last without valid
        step(1, W'(100), 0, 1);
        step(0, W'(55), 1, 1);
        step(1, W'(200), 0, 1);
        step(0, W'(66), 1, 1);
        step(1, W'(300), 1, 1);
        step(0, '0, 0, 1);

        // reset mid-group, then reset while result pending
        step(1, W'(10), 0, 1);
        step(1, W'(20), 0, 1);
        do_reset(1'b0);
        step(1, W'(4), 1, 1);
        step(0, '0, 0, 1);
        step(1, W'(7), 1, 0);
        do_reset(1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 3) != 0), rand_data(),
                     1'($urandom_range(0, 4) == 0),
                     1'($urandom_range(0, 2) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
